wash_start_sequencer: RTL and testbench

Front-panel sequencer that sits directly upstream of the wash controller. It turns raw start and cancel buttons plus the door switch into a locked, supervised run. While running, it drives a one-cycle step_tick per minute into the controller's step input. It watches cycle_done from the controller to end the run, unlocks the door, and flags door-open and overtime faults.

---
 rtl/wash_pkg.sv | 22 ++
 rtl/wash_debounce.sv | 58 +++++
 rtl/wash_start_sequencer.sv | 143 ++++++++++++++
 tb/tb_wash_start_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/wash_pkg.sv
// Shared types and default timing for the wash start sequencer.
package wash_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOCK   = 3'd1,
        RUN    = 3'd2,
        UNLOCK = 3'd3,
        FAULT  = 3'd4
    } state_e;

    localparam int MINUTE_W = 7;

    localparam int DEF_TICK_DIV        = 6000;
    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_LOCK_CYCLES     = 50;
    localparam int DEF_UNLOCK_CYCLES   = 50;
    localparam int DEF_MAX_MINUTES     = 110;

    localparam logic [MINUTE_W-1:0] MINUTE_SAT = '1;

endpackage

// File: rtl/wash_debounce.sv
// Two-flop synchroniser, stable-count debouncer and rising-edge event for
// one front-panel input.
module wash_debounce
    import wash_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Any cycle where the synchronised value agrees with the level restarts
    // the count, so only an unbroken run of disagreement flips the level.
    always_comb begin
        level_d = level_q;
        rise_d  = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/wash_start_sequencer.sv
// Front-panel run sequencer: door locking, minute ticks to the wash
// controller, run-end unlock and door/overtime fault supervision.
module wash_start_sequencer
    import wash_pkg::*;
#(
    parameter int TICK_DIV        = DEF_TICK_DIV,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LOCK_CYCLES     = DEF_LOCK_CYCLES,
    parameter int UNLOCK_CYCLES   = DEF_UNLOCK_CYCLES,
    parameter int MAX_MINUTES     = DEF_MAX_MINUTES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                btn_start_raw,
    input  logic                btn_cancel_raw,
    input  logic                door_closed_raw,
    input  logic                cycle_done,
    output logic                step_tick,
    output logic                running,
    output logic                door_lock,
    output logic                fault,
    output logic                cycle_end,
    output logic [MINUTE_W-1:0] minute_count
);

    localparam int PRE_W = $clog2(TICK_DIV);
    localparam int TMR_MAX = (LOCK_CYCLES > UNLOCK_CYCLES) ? LOCK_CYCLES : UNLOCK_CYCLES;
    localparam int TMR_W = $clog2(TMR_MAX + 1);

    localparam logic [PRE_W-1:0]    PRE_LAST    = PRE_W'(TICK_DIV - 1);
    localparam logic [TMR_W-1:0]    LOCK_LAST   = TMR_W'(LOCK_CYCLES - 1);
    localparam logic [TMR_W-1:0]    UNLOCK_LAST = TMR_W'(UNLOCK_CYCLES - 1);
    localparam logic [MINUTE_W-1:0] MAX_MIN     = MINUTE_W'(MAX_MINUTES);

    logic start_ev, cancel_ev, door_closed;
    logic start_lvl, cancel_lvl, door_rise;
    logic unused_dbnc;

    wash_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
        .clk(clk), .rst_n(rst_n), .raw(btn_start_raw), .level(start_lvl), .rise(start_ev)
    );
    wash_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cancel (
        .clk(clk), .rst_n(rst_n), .raw(btn_cancel_raw), .level(cancel_lvl), .rise(cancel_ev)
    );
    wash_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_door (
        .clk(clk), .rst_n(rst_n), .raw(door_closed_raw), .level(door_closed), .rise(door_rise)
    );

    assign unused_dbnc = ^{start_lvl, cancel_lvl, door_rise};

    state_e              state_q, state_d;
    logic [PRE_W-1:0]    prescaler_q, prescaler_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [MINUTE_W-1:0] minute_q, minute_d;
    logic                tick;
    logic                step_tick_q, step_tick_d;
    logic                running_q, running_d;
    logic                door_lock_q, door_lock_d;
    logic                fault_q, fault_d;
    logic                cycle_end_q, cycle_end_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            prescaler_q <= '0;
            timer_q     <= '0;
            minute_q    <= '0;
            step_tick_q <= 1'b0;
            running_q   <= 1'b0;
            door_lock_q <= 1'b0;
            fault_q     <= 1'b0;
            cycle_end_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            prescaler_q <= prescaler_d;
            timer_q     <= timer_d;
            minute_q    <= minute_d;
            step_tick_q <= step_tick_d;
            running_q   <= running_d;
            door_lock_q <= door_lock_d;
            fault_q     <= fault_d;
            cycle_end_q <= cycle_end_d;
        end
    end

    // Prescaler and timers fall back to zero whenever they are not advancing.
    always_comb begin
        state_d     = state_q;
        prescaler_d = '0;
        timer_d     = '0;
        minute_d    = minute_q;
        tick        = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_ev && door_closed) begin
                    state_d  = LOCK;
                    minute_d = '0;
                end
            end
            LOCK: begin
                if (!door_closed || cancel_ev)  state_d = IDLE;
                else if (timer_q == LOCK_LAST)  state_d = RUN;
                else                            timer_d = timer_q + 1'b1;
            end
            RUN: begin
                if (!door_closed)                 state_d = FAULT;
                else if (cycle_done || cancel_ev) state_d = UNLOCK;
                else if (minute_q == MAX_MIN)     state_d = FAULT;
                else if (prescaler_q == PRE_LAST) begin
                    tick = 1'b1;
                    if (minute_q != MINUTE_SAT) minute_d = minute_q + 1'b1;
                end else begin
                    prescaler_d = prescaler_q + 1'b1;
                end
            end
            UNLOCK: begin
                if (timer_q == UNLOCK_LAST) state_d = IDLE;
                else                        timer_d = timer_q + 1'b1;
            end
            FAULT: begin
                if (cancel_ev) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register with it.
    always_comb begin
        step_tick_d = tick;
        running_d   = (state_d == RUN);
        door_lock_d = (state_d == LOCK) || (state_d == RUN) || (state_d == UNLOCK);
        fault_d     = (state_d == FAULT);
        cycle_end_d = (state_q == UNLOCK) && (state_d == IDLE);
    end

    assign step_tick    = step_tick_q;
    assign running      = running_q;
    assign door_lock    = door_lock_q;
    assign fault        = fault_q;
    assign cycle_end    = cycle_end_q;
    assign minute_count = minute_q;

endmodule

// File: tb/tb_wash_start_sequencer.sv
// Scoreboarded bench: scenarios queue the output events they expect, a
// negedge monitor pops and compares each event the sequencer produces.
module tb_wash_start_sequencer;

    localparam int K_TICK = 1, K_LOCKR = 2, K_LOCKF = 3, K_RUNR = 4, K_RUNF = 5;
    localparam int K_FLTR = 6, K_FLTF = 7, K_CEND = 8;

    typedef struct {
        int cyc;
        int code;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n, btn_start_raw, btn_cancel_raw, door_closed_raw, cycle_done;
    logic       step_tick, running, door_lock, fault, cycle_end;
    logic [6:0] minute_count;
    logic [11:0] outs;

    int  cyc = 0;
    int  n_tests = 0;
    int  n_fail = 0;
    bit  mon_en = 1'b0;
    logic p_tick = 1'b0, p_lock = 1'b0, p_run = 1'b0, p_flt = 1'b0, p_cend = 1'b0;
    ev_t exp_q[$];

    wash_start_sequencer #(
        .TICK_DIV(10), .DEBOUNCE_CYCLES(4), .LOCK_CYCLES(3),
        .UNLOCK_CYCLES(3), .MAX_MINUTES(5)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_start_raw(btn_start_raw), .btn_cancel_raw(btn_cancel_raw),
        .door_closed_raw(door_closed_raw), .cycle_done(cycle_done),
        .step_tick(step_tick), .running(running), .door_lock(door_lock),
        .fault(fault), .cycle_end(cycle_end), .minute_count(minute_count)
    );

    assign outs = {step_tick, running, door_lock, fault, cycle_end, minute_count};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic expect_ev(input int c, input int kind, input int minute);
        ev_t e;
        e.cyc  = c;
        e.code = kind * 256 + minute;
        exp_q.push_back(e);
    endtask

    task automatic ev(input int kind, input int minute);
        int  code;
        ev_t e;
        code = kind * 256 + minute;
        if (exp_q.size() == 0) begin
            chk($sformatf("ev_k%0d_unexpected", kind), code, 0);
        end else begin
            e = exp_q.pop_front();
            chk($sformatf("ev_k%0d_code", kind), code, e.code);
            chk($sformatf("ev_k%0d_cycle", kind), cyc, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (step_tick && !p_tick) ev(K_TICK, int'(minute_count));
            if (door_lock && !p_lock) ev(K_LOCKR, 0);
            if (!door_lock && p_lock) ev(K_LOCKF, 0);
            if (running && !p_run)    ev(K_RUNR, 0);
            if (!running && p_run)    ev(K_RUNF, 0);
            if (fault && !p_flt)      ev(K_FLTR, 0);
            if (!fault && p_flt)      ev(K_FLTF, 0);
            if (cycle_end && !p_cend) ev(K_CEND, int'(minute_count));
            p_tick <= step_tick;
            p_lock <= door_lock;
            p_run  <= running;
            p_flt  <= fault;
            p_cend <= cycle_end;
        end
    end

    task automatic goto(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic press(input bit s, input bit c, input int hold);
        btn_start_raw  = s;
        btn_cancel_raw = c;
        repeat (hold) @(negedge clk);
        btn_start_raw  = 1'b0;
        btn_cancel_raw = 1'b0;
    endtask

    initial begin
        int c0, c1;
        rst_n = 1'b0;
        btn_start_raw = 1'b0;
        btn_cancel_raw = 1'b0;
        door_closed_raw = 1'b0;
        cycle_done = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("reset_outputs", outs, 0);
        mon_en = 1'b1;
        door_closed_raw = 1'b1;
        repeat (10) @(negedge clk);

        // Held start: one run, three ticks, then controller reports done
        c0 = cyc;
        expect_ev(c0 + 7, K_LOCKR, 0);
        expect_ev(c0 + 10, K_RUNR, 0);
        expect_ev(c0 + 20, K_TICK, 1);
        expect_ev(c0 + 30, K_TICK, 2);
        expect_ev(c0 + 40, K_TICK, 3);
        expect_ev(c0 + 41, K_RUNF, 0);
        expect_ev(c0 + 44, K_LOCKF, 0);
        expect_ev(c0 + 44, K_CEND, 3);
        press(1, 0, 20);
        goto(c0 + 40);
        cycle_done = 1'b1;
        goto(c0 + 50);
        cycle_done = 1'b0;
        chk("t1_queue_drained", exp_q.size(), 0);
        chk("t1_minutes", minute_count, 3);

        // Done after two ticks
        c0 = cyc;
        expect_ev(c0 + 7, K_LOCKR, 0);
        expect_ev(c0 + 10, K_RUNR, 0);
        expect_ev(c0 + 20, K_TICK, 1);
        expect_ev(c0 + 30, K_TICK, 2);
        expect_ev(c0 + 31, K_RUNF, 0);
        expect_ev(c0 + 34, K_LOCKF, 0);
        expect_ev(c0 + 34, K_CEND, 2);
        press(1, 0, 10);
        goto(c0 + 30);
        cycle_done = 1'b1;
        goto(c0 + 45);
        cycle_done = 1'b0;
        chk("t2_queue_drained", exp_q.size(), 0);
        chk("t2_minutes", minute_count, 2);

        // Start with door open is ignored
        door_closed_raw = 1'b0;
        repeat (10) @(negedge clk);
        press(1, 0, 10);
        repeat (20) @(negedge clk);
        chk("t3_open_lock", door_lock, 0);
        chk("t3_open_fault", fault, 0);
        chk("t3_open_queue", exp_q.size(), 0);
        door_closed_raw = 1'b1;
        repeat (10) @(negedge clk);

        // Start+cancel together in IDLE starts; door opens in RUN -> fault
        c0 = cyc;
        expect_ev(c0 + 7, K_LOCKR, 0);
        expect_ev(c0 + 10, K_RUNR, 0);
        expect_ev(c0 + 20, K_TICK, 1);
        expect_ev(c0 + 30, K_TICK, 2);
        expect_ev(c0 + 32, K_LOCKF, 0);
        expect_ev(c0 + 32, K_RUNF, 0);
        expect_ev(c0 + 32, K_FLTR, 0);
        press(1, 1, 10);
        goto(c0 + 25);
        door_closed_raw = 1'b0;
        goto(c0 + 35);
        door_closed_raw = 1'b1;
        goto(c0 + 45);
        press(1, 0, 10);
        goto(c0 + 60);
        chk("t4_fault_held", fault, 1);
        chk("t4_fault_unlocked", door_lock, 0);
        chk("t4_fault_minutes", minute_count, 2);
        c1 = cyc;
        expect_ev(c1 + 7, K_FLTF, 0);
        press(0, 1, 10);
        goto(c1 + 15);
        chk("t4_cancel_clears", fault, 0);
        chk("t4_queue_drained", exp_q.size(), 0);

        // Overtime watchdog after the fifth minute
        c0 = cyc;
        expect_ev(c0 + 7, K_LOCKR, 0);
        expect_ev(c0 + 10, K_RUNR, 0);
        for (int m = 1; m <= 5; m++) expect_ev(c0 + 10 + 10 * m, K_TICK, m);
        expect_ev(c0 + 61, K_LOCKF, 0);
        expect_ev(c0 + 61, K_RUNF, 0);
        expect_ev(c0 + 61, K_FLTR, 0);
        press(1, 0, 10);
        goto(c0 + 70);
        chk("t5_minutes", minute_count, 5);
        chk("t5_fault", fault, 1);
        c1 = cyc;
        expect_ev(c1 + 7, K_FLTF, 0);
        press(0, 1, 10);
        goto(c1 + 15);
        chk("t5_queue_drained", exp_q.size(), 0);

        // Reset mid-run, restart, short cancel glitch, then real cancel
        c0 = cyc;
        expect_ev(c0 + 7, K_LOCKR, 0);
        expect_ev(c0 + 10, K_RUNR, 0);
        expect_ev(c0 + 20, K_TICK, 1);
        expect_ev(c0 + 26, K_LOCKF, 0);
        expect_ev(c0 + 26, K_RUNF, 0);
        press(1, 0, 10);
        goto(c0 + 25);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t6_reset_outputs", outs, 0);
        goto(c0 + 35);
        c1 = cyc;
        expect_ev(c1 + 7, K_LOCKR, 0);
        expect_ev(c1 + 10, K_RUNR, 0);
        for (int m = 1; m <= 4; m++) expect_ev(c1 + 10 + 10 * m, K_TICK, m);
        expect_ev(c1 + 52, K_RUNF, 0);
        expect_ev(c1 + 55, K_LOCKF, 0);
        expect_ev(c1 + 55, K_CEND, 4);
        press(1, 0, 10);
        goto(c1 + 25);
        press(0, 1, 3);
        goto(c1 + 45);
        press(0, 1, 8);
        goto(c1 + 65);
        chk("t6_queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
